riscv_mc_ctrl: RTL and testbench
================================

// Module: riscv_mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32 core subset: lw, sw, R-type, I-type ALU, beq/bne/blt.
//  Sequences a shared-ALU, single-memory datapath through fetch/decode/execute/memory/writeback.
//  Drives the PC, IR and register-file enables, mux selects, ALU opcode and the memory handshake.
//  Replaces the single-cycle decoder when the core is built as a multi-cycle machine.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles to wait for mem_ready before entering TRAP; 0 disables the timeout
// PORTS
//  clk          in   1  core clock; all state changes on the rising edge
//  rst          in   1  synchronous, active-high reset
//  op           in   7  IR[6:0] opcode
//  funct3       in   3  IR[14:12]
//  funct7b5     in   1  IR[30]
//  zero         in   1  ALU result == 0, combinational from the datapath
//  sign         in   1  ALU result[31], combinational from the datapath
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request, held until mem_ready
//  mem_write    out  1  qualifies mem_req as a store
//  adr_src      out  1  0: address = PC, 1: address = ALUOut
//  ir_write     out  1  load IR (and OldPC) from read data
//  pc_write     out  1  load PC from the result bus
//  reg_write    out  1  register-file write enable
//  alu_src_a    out  2  00 PC, 01 OldPC, 10 rs1 register
//  alu_src_b    out  2  00 rs2 register, 01 ImmExt, 10 constant 4
//  result_src   out  2  00 ALUOut, 01 read data, 10 ALU result
//  imm_src      out  2  00 I-type, 01 S-type, 10 B-type
//  alu_control  out  3  000 add, 010 subtract, otherwise funct3 pass-through
//  trap         out  1  sticky; set on an illegal opcode or a memory timeout
// BEHAVIOUR
//  - Reset: state = FETCH, timeout counter = 0, trap = 0. All outputs except those decoded from FETCH are 0.
//  - Outputs are Moore decodes of the state. The exception is pc_write in BRANCH, which also depends on zero/sign.
//  - FETCH: mem_req=1, adr_src=0. Stay in FETCH while mem_ready=0.
//    On mem_ready: ir_write=1, pc_write=1 with PC+4 (src_a=00, src_b=10, add, result_src=10), then go to DECODE.
//  - DECODE: src_a=01, src_b=01, imm_src=10, add, so ALUOut = branch target. Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; any other op -> TRAP.
//  - MEMADR: src_a=10, src_b=01, add; imm_src=00 for a load, 01 for a store. Next: MEMREAD (load) or MEMWRITE (store).
//  - MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
//  - MEMWB: result_src=01, reg_write=1, then go to FETCH.
//  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then go to FETCH.
//  - EXECR: src_a=10, src_b=00. EXECI: src_a=10, src_b=01, imm_src=00. Both then go to ALUWB.
//    ALU code: funct3=000 gives subtract (010) only if op[5] & funct7b5, otherwise add; any other funct3 passes through.
//  - ALUWB: result_src=00, reg_write=1, then go to FETCH.
//  - BRANCH: src_a=10, src_b=00, subtract, result_src=00 (ALUOut = target).
//    pc_write = zero for funct3 000, !zero for 001, sign for 100; 0 for any other funct3. Then go to FETCH.
//  - TRAP: all enables 0, trap=1, held until rst.
//  - Timeout: the counter clears on every state change and counts while mem_req=1 & !mem_ready.
//    When it reaches MEM_TIMEOUT (and MEM_TIMEOUT != 0) the FSM goes to TRAP.
//  - mem_req must not drop before mem_ready. A mem_ready seen outside a memory state is ignored.
//  - rst asserted mid-access: the FSM returns to FETCH on the next edge and mem_req drops; no stale write completes.
//  - Latency: lw 5 cycles, sw 4, R/I-type 4, branch 3 (all with zero-wait memory).
// STRUCTURE
//  - Package riscv_pkg: opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH), ALU codes,
//    state enum (FETCH..TRAP, 4-bit), and the src_a/src_b/result_src/imm_src encodings.
//  - One sub-module riscv_alu_dec: combinational (alu_op, funct3, op5, funct7b5) -> alu_control.
//  - The FSM, the timeout counter and the branch decision stay in riscv_mc_ctrl.
// TESTING
//  1. add x3,x1,x2 with zero-wait memory: FETCH,DECODE,EXECR,ALUWB; reg_write high only in cycle 4;
//     alu_control=000 in EXECR.
//  2. lw with mem_ready low for 3 cycles in MEMREAD: mem_req held for 4 cycles; 8 cycles total;
//     result_src=01 in MEMWB.
//  3. beq with zero=1 -> pc_write=1 in BRANCH; with zero=0 -> 0. bne mirrored; blt with sign=1 -> taken;
//     funct3=010 -> never taken.
//  4. sub (funct7b5=1, op=0110011) -> alu_control=010; addi with IR[30]=1 -> alu_control=000.
//  5. op=1111111 -> TRAP after DECODE, trap=1, no further mem_req; rst -> FETCH.
//  6. MEM_TIMEOUT=16 with mem_ready stuck low in FETCH -> TRAP after exactly 16 cycles;
//     rst pulsed during MEMWRITE -> no further mem_write.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32 control path:
// opcodes, ALU codes, FSM states and datapath mux encodings.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/riscv_alu_dec.sv
// ALU control decoder: maps the FSM's coarse ALU request
// plus instruction fields onto the 3-bit ALU opcode.
module riscv_alu_dec
  import riscv_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    unique case (alu_op_i)
      AOP_SUB: alu_control_o = ALU_SUB;
      AOP_FUNCT: begin
        // addi shares funct3=000 with add/sub; only R-type may subtract
        if (funct3_i == 3'b000)
          alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
        else
          alu_control_o = funct3_i;
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control FSM for the RV32 subset (lw/sw/R/I/branch)
// with a memory-handshake timeout that parks the core in TRAP.
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       trap
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            trap_q;
  alu_op_t         alu_op;
  logic            br_taken;
  logic            mem_wait;
  logic            timeout;

  riscv_alu_dec u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_control)
  );

  always_comb begin
    br_taken = 1'b0;
    unique case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = AOP_ADD;
    unique case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SRCB_4;
        result_src = RES_ALU;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = AOP_FUNCT;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = AOP_FUNCT;
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = AOP_SUB;
        pc_write  = br_taken;
      end
      default: ;
    endcase
  end

  assign mem_wait = mem_req & ~mem_ready;
  assign timeout  = (MEM_TIMEOUT != 0) && mem_wait &&
                    (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      MEMWB:    state_d = FETCH;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
    if (timeout) state_d = TRAP;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_q | (state_d == TRAP);
    end
  end

  assign trap = trap_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: a per-instruction phase
// model pushes expected outputs, a monitor compares each cycle.
module tb_riscv_mc_ctrl;

  localparam int TO = 16;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_write, adr_src, ir_write;
  logic       pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;

  typedef struct packed {
    logic       mr;
    logic       mw;
    logic       adr;
    logic       ir;
    logic       pw;
    logic       rw;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [1:0] im;
    logic [2:0] alu;
    logic       tr;
  } obs_t;

  obs_t  act;
  obs_t  exp_q[$];
  obs_t  care_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .sign        (sign),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .trap        (trap)
  );

  assign act = {mem_req, mem_write, adr_src, ir_write,
                pc_write, reg_write, alu_src_a, alu_src_b,
                result_src, imm_src, alu_control, trap};

  // Expected outputs for one cycle; a negative select means "don't care".
  function automatic void ph(string tag,
    bit mr, bit mw, bit ir, bit pw, bit rw, bit tr,
    int adr, int sa, int sb, int rs, int im, int alu);
    obs_t e, c;
    e = '0;
    c = '0;
    e.mr = mr; e.mw = mw; e.ir = ir;
    e.pw = pw; e.rw = rw; e.tr = tr;
    c.mr = 1'b1; c.mw = 1'b1; c.ir = 1'b1;
    c.pw = 1'b1; c.rw = 1'b1; c.tr = 1'b1;
    if (adr >= 0) begin e.adr = adr[0];   c.adr = 1'b1; end
    if (sa >= 0)  begin e.sa  = sa[1:0];  c.sa  = '1;   end
    if (sb >= 0)  begin e.sb  = sb[1:0];  c.sb  = '1;   end
    if (rs >= 0)  begin e.rs  = rs[1:0];  c.rs  = '1;   end
    if (im >= 0)  begin e.im  = im[1:0];  c.im  = '1;   end
    if (alu >= 0) begin e.alu = alu[2:0]; c.alu = '1;   end
    exp_q.push_back(e);
    care_q.push_back(c);
    tag_q.push_back(tag);
  endfunction

  always @(negedge clk) begin
    obs_t  e, c;
    string t;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = care_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (((act ^ e) & c) != '0) begin
        errors++;
        $display("FAIL %s t=%0t act=%h exp=%h care=%h",
                 t, $time, act, e, c);
      end
    end
  end

  function automatic bit taken(logic [2:0] f3, bit z, bit s);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return s;
    return 1'b0;
  endfunction

  task automatic step(input bit rdy);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = rdy;
    zero      = 1'($urandom);
    sign      = 1'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_ready = 1'($urandom);
  endtask

  task automatic trap_seq();
    for (int k = 0; k < 4; k++) begin
      step(1'($urandom));
      ph("trap", 0, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1, -1);
    end
    do_reset();
  endtask

  // One whole instruction; bz/bs force the branch flags when >= 0,
  // abort pulses rst during the first memory wait cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
    input bit f7, input int fw, input int mw,
    input int bz, input int bs, input bit abort);
    int n;
    bit st;
    bit is_r;
    int ac;
    n = (fw < TO) ? fw : TO;
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      ph("fetch_wait", 1, 0, 0, 0, 0, 0, 0, 0, 2, 2, -1, 0);
    end
    if (fw >= TO) begin
      trap_seq();
      return;
    end
    step(1'b1);
    ph("fetch", 1, 0, 1, 1, 0, 0, 0, 0, 2, 2, -1, 0);
    step(1'($urandom));
    op = o; funct3 = f3; funct7b5 = f7;
    ph("decode", 0, 0, 0, 0, 0, 0, -1, 1, 1, -1, 2, 0);
    if (o == LD || o == ST) begin
      st = (o == ST);
      step(1'($urandom));
      ph("memadr", 0, 0, 0, 0, 0, 0, -1, 2, 1, -1, st ? 1 : 0, 0);
      n = (mw < TO) ? mw : TO;
      for (int i = 0; i < n; i++) begin
        step(1'b0);
        ph(st ? "memwr_wait" : "memrd_wait",
           1, st, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1);
        if (abort) begin
          do_reset();
          return;
        end
      end
      if (mw >= TO) begin
        trap_seq();
        return;
      end
      step(1'b1);
      ph(st ? "memwr" : "memrd",
         1, st, 0, 0, 0, 0, 1, -1, -1, -1, -1, -1);
      if (!st) begin
        step(1'($urandom));
        ph("memwb", 0, 0, 0, 0, 1, 0, -1, -1, -1, 1, -1, -1);
      end
    end else if (o == RT || o == IT) begin
      is_r = (o == RT);
      if (f3 != 3'b000) ac = int'(f3);
      else ac = (is_r && f7) ? 2 : 0;
      step(1'($urandom));
      ph(is_r ? "execr" : "execi", 0, 0, 0, 0, 0, 0,
         -1, 2, is_r ? 0 : 1, -1, is_r ? -1 : 0, ac);
      step(1'($urandom));
      ph("aluwb", 0, 0, 0, 0, 1, 0, -1, -1, -1, 0, -1, -1);
    end else if (o == BR) begin
      step(1'($urandom));
      if (bz >= 0) zero = bz[0];
      if (bs >= 0) sign = bs[0];
      ph("branch", 0, 0, 0, taken(f3, zero, sign), 0, 0,
         -1, 2, 0, 0, -1, 2);
    end else begin
      trap_seq();
    end
  endtask

  initial begin
    logic [6:0] ill;
    int         cls;
    int         fw;
    int         mw;
    @(posedge clk);
    do_reset();
    run_instr(RT, 3'b000, 1'b0, 0, 0, -1, -1, 1'b0);
    run_instr(LD, 3'b010, 1'b0, 0, 3, -1, -1, 1'b0);
    run_instr(BR, 3'b000, 1'b0, 0, 0, 1, 0, 1'b0);
    run_instr(BR, 3'b000, 1'b0, 0, 0, 0, 1, 1'b0);
    run_instr(BR, 3'b001, 1'b0, 0, 0, 1, 0, 1'b0);
    run_instr(BR, 3'b001, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr(BR, 3'b100, 1'b0, 0, 0, 0, 1, 1'b0);
    run_instr(BR, 3'b100, 1'b0, 0, 0, 1, 0, 1'b0);
    run_instr(BR, 3'b010, 1'b0, 0, 0, 1, 1, 1'b0);
    run_instr(BR, 3'b010, 1'b0, 0, 0, 0, 1, 1'b0);
    run_instr(RT, 3'b000, 1'b1, 0, 0, -1, -1, 1'b0);
    run_instr(IT, 3'b000, 1'b1, 0, 0, -1, -1, 1'b0);
    run_instr(ST, 3'b010, 1'b0, 1, 2, -1, -1, 1'b0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, -1, -1, 1'b0);
    run_instr(RT, 3'b000, 1'b0, TO + 2, 0, -1, -1, 1'b0);
    run_instr(ST, 3'b010, 1'b0, 0, 3, -1, -1, 1'b1);
    run_instr(RT, 3'b111, 1'b0, 2, 0, -1, -1, 1'b0);
    run_instr(ST, 3'b010, 1'b0, 0, TO, -1, -1, 1'b0);
    run_instr(LD, 3'b010, 1'b0, 0, TO - 1, -1, -1, 1'b0);
    run_instr(RT, 3'b000, 1'b0, TO - 1, 0, -1, -1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      cls = $urandom_range(0, 19);
      fw  = ($urandom_range(0, 39) == 0) ? TO : $urandom_range(0, 3);
      mw  = ($urandom_range(0, 39) == 0) ? TO + 1 : $urandom_range(0, 3);
      if (cls < 4)       op = LD;
      else if (cls < 8)  op = ST;
      else if (cls < 12) op = RT;
      else if (cls < 15) op = IT;
      else if (cls < 19) op = BR;
      else begin
        ill = 7'($urandom);
        while (ill == LD || ill == ST || ill == RT ||
               ill == IT || ill == BR)
          ill = 7'($urandom);
        op = ill;
      end
      run_instr(op, 3'($urandom), 1'($urandom), fw, mw,
                -1, -1, ($urandom_range(0, 29) == 0));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
